// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package ssd_pkg;

  localparam int SEG_W = 7;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Never narrower than one bit, so single-entry spaces stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Nibble to active-high seven-segment pattern.
// Output polarity is applied by the parent.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0]       i_nib,
  output logic [SEG_W-1:0] o_seg
);

  assign o_seg = SEG_LUT[i_nib];

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed NUM_DIGITS hex display driver with register bank.
// Define SSD_SCAN_BLINK_EN to add per-digit blink masking.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
`ifdef SSD_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 32
`endif
)(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ena,
  input  logic                             wr_en,
  input  logic [idx_width(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                       wr_data,
  input  logic                             wr_dp,
  input  logic                             lz_blank_en,
`ifdef SSD_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]            blink_mask,
`endif
  output logic [SEG_W-1:0]                 seg_out,
  output logic                             dp_out,
  output logic [NUM_DIGITS-1:0]            dig_sel,
  output logic                             frame_tick
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int CW = idx_width(REFRESH_DIV);
  localparam bit SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam bit DIG_INV = (DIG_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0] SEG_OFF =
    SEG_INV ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    DIG_INV ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [3:0]            r_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_dp;
  logic [CW-1:0]         r_slot;
  logic [IW-1:0]         r_idx;
  logic [SEG_W-1:0]      r_seg;
  logic                  r_dp_o;
  logic [NUM_DIGITS-1:0] r_sel;
  logic                  r_tick;

  logic                  w_addr_ok;
  logic                  w_slot_end;
  logic                  w_frame_end;
  logic [NUM_DIGITS-1:0] w_upper;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [NUM_DIGITS-1:0] w_blank;
  logic [3:0]            w_nib;
  logic [SEG_W-1:0]      w_seg_raw;
  logic [SEG_W-1:0]      w_seg;
  logic                  w_dp;
  logic [NUM_DIGITS-1:0] w_sel;

  assign w_addr_ok   = {1'b0, wr_addr} < (IW+1)'(NUM_DIGITS);
  assign w_slot_end  = r_slot == CW'(REFRESH_DIV-1);
  assign w_frame_end = w_slot_end && (r_idx == IW'(NUM_DIGITS-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) r_dig[k] <= '0;
      r_dp <= '0;
    end else if (wr_en && w_addr_ok) begin
      r_dig[wr_addr] <= wr_data;
      r_dp[wr_addr]  <= wr_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0;
      r_idx  <= '0;
    end else if (ena) begin
      if (w_slot_end) begin
        r_slot <= '0;
        r_idx  <= (r_idx == IW'(NUM_DIGITS-1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_slot <= r_slot + 1'b1;
      end
    end
  end

  // w_upper[k]: digit k and every digit above it are zero with no dp.
  always_comb begin
    logic v_run;
    v_run   = 1'b1;
    w_upper = '0;
    for (int k = NUM_DIGITS-1; k >= 0; k--) begin
      v_run      = v_run && (r_dig[k] == 4'h0) && !r_dp[k];
      w_upper[k] = v_run;
    end
  end

  assign w_lz = lz_blank_en ? (w_upper & ~NUM_DIGITS'(1)) : '0;

`ifdef SSD_SCAN_BLINK_EN
  localparam int FW = idx_width(BLINK_FRAMES);
  logic [FW-1:0] r_fcnt;
  logic          r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (ena && w_frame_end) begin
      if (r_fcnt == FW'(BLINK_FRAMES-1)) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_blank = w_lz | (r_phase ? blink_mask : '0);
`else
  assign w_blank = w_lz;
`endif

  assign w_nib = r_dig[r_idx];

  ssd_hex_decoder u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg_raw)
  );

  assign w_seg = w_blank[r_idx] ? '0 : w_seg_raw;
  assign w_dp  = !w_blank[r_idx] && r_dp[r_idx];
  assign w_sel = (r_slot >= CW'(BLANK_CYCLES)) ?
                 (NUM_DIGITS'(1) << r_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      r_seg  <= SEG_OFF;
      r_dp_o <= SEG_INV;
      r_sel  <= DIG_OFF;
      r_tick <= 1'b0;
    end else begin
      r_seg  <= SEG_INV ? ~w_seg : w_seg;
      r_dp_o <= SEG_INV ? !w_dp : w_dp;
      r_sel  <= DIG_INV ? ~w_sel : w_sel;
      r_tick <= w_frame_end;
    end
  end

  assign seg_out    = r_seg;
  assign dp_out     = r_dp_o;
  assign dig_sel    = r_sel;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: reference model scoreboard plus
// directed scenarios on a 4-digit and a 5-digit instance.
module tb_ssd_scan_driver;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_dp = 1'b0;
  logic       lz = 1'b0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] dig_sel;
  logic       frame_tick;

  logic       wr_en5 = 1'b0;
  logic [2:0] wr_addr5 = '0;
  logic [3:0] wr_data5 = '0;
  logic [6:0] seg5;
  logic       dp5;
  logic [4:0] dig5;
  logic       ft5;

  int total = 0;
  int bad = 0;

`ifdef SSD_SCAN_BLINK_EN
  logic [3:0] blink4 = '0;
  logic [4:0] blink5 = '0;
`endif

  always #5 clk = ~clk;

  ssd_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
  ) u_dut (
    .clk(clk), .rst(rst), .ena(ena),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp),
    .lz_blank_en(lz),
`ifdef SSD_SCAN_BLINK_EN
    .blink_mask(blink4),
`endif
    .seg_out(seg_out), .dp_out(dp_out),
    .dig_sel(dig_sel), .frame_tick(frame_tick)
  );

  ssd_scan_driver #(
    .NUM_DIGITS(5), .REFRESH_DIV(R), .BLANK_CYCLES(B),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
  ) u_dut5 (
    .clk(clk), .rst(rst), .ena(ena),
    .wr_en(wr_en5), .wr_addr(wr_addr5),
    .wr_data(wr_data5), .wr_dp(1'b0),
    .lz_blank_en(1'b0),
`ifdef SSD_SCAN_BLINK_EN
    .blink_mask(blink5),
`endif
    .seg_out(seg5), .dp_out(dp5),
    .dig_sel(dig5), .frame_tick(ft5)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] sel;
    logic       ft;
  } obs_t;

  obs_t sb_q[$];

  logic [3:0] m_dig [N];
  logic [3:0] m_dp;
  int         m_slot;
  int         m_idx;

  // Reference model: predicts next registered outputs each edge.
  always @(posedge clk) begin : model
    obs_t e;
    logic blank;
    e = '{seg: 7'h00, dp: 1'b0, sel: 4'hF, ft: 1'b0};
    if (!rst && ena) begin
      blank = 1'b0;
      if (lz && m_idx != 0) begin
        blank = 1'b1;
        for (int j = m_idx; j < N; j++)
          if (m_dig[j] != 0 || m_dp[j]) blank = 1'b0;
      end
      e.seg = blank ? 7'h00 : SEG_TBL[m_dig[m_idx]];
      e.dp  = blank ? 1'b0 : m_dp[m_idx];
      if (m_slot >= B) e.sel = ~(4'b0001 << m_idx);
      e.ft = (m_slot == R-1) && (m_idx == N-1);
    end
    sb_q.push_back(e);
    if (rst) begin
      for (int j = 0; j < N; j++) m_dig[j] <= '0;
      m_dp   <= '0;
      m_slot <= 0;
      m_idx  <= 0;
    end else begin
      if (wr_en) begin
        m_dig[wr_addr] <= wr_data;
        m_dp[wr_addr]  <= wr_dp;
      end
      if (ena) begin
        if (m_slot == R-1) begin
          m_slot <= 0;
          m_idx  <= (m_idx + 1) % N;
        end else begin
          m_slot <= m_slot + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : scoreboard
    obs_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if ({seg_out, dp_out, dig_sel, frame_tick} !== e) begin
        bad++;
        $display("FAIL scan t=%0t got seg=%h dp=%b sel=%b ft=%b want seg=%h dp=%b sel=%b ft=%b",
                 $time, seg_out, dp_out, dig_sel, frame_tick,
                 e.seg, e.dp, e.sel, e.ft);
      end
    end
  end

  task automatic wait_sel(input logic [3:0] want, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (dig_sel === want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ft(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wr4(input logic [1:0] a, input logic [3:0] d,
                     input logic p);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_dp = p;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] want_sel;
    repeat (3) @(negedge clk);
    total++;
    if ({seg_out, dp_out, dig_sel, frame_tick} !== {7'h00, 1'b0, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got seg=%h dp=%b sel=%b ft=%b want 00/0/1111/0",
               seg_out, dp_out, dig_sel, frame_tick);
    end
    rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      want_sel = (c >= 3 && c <= 8) ? 4'b1110 : 4'b1111;
      total++;
      if (dig_sel !== want_sel || seg_out !== 7'h3F) begin
        bad++;
        $display("FAIL reset_seq c=%0d got sel=%b seg=%h want sel=%b seg=3f",
                 c, dig_sel, seg_out, want_sel);
      end
    end
  endtask

  task automatic test_writes();
    logic [3:0] vals [4];
    logic [6:0] want [4];
    bit ok;
    int cnt;
    vals = '{4'hF, 4'hA, 4'h2, 4'h1};
    want = '{7'h71, 7'h77, 7'h5B, 7'h06};
    for (int k = 3; k >= 0; k--) wr4(k[1:0], vals[k], 1'b0);
    wait_ft(ok);
    for (int k = 0; k < N; k++) begin
      wait_sel(~(4'b0001 << k), ok);
      total++;
      if (!ok || seg_out !== want[k]) begin
        bad++;
        $display("FAIL write_seg idx=%0d ok=%0b got %h want %h",
                 k, ok, seg_out, want[k]);
      end
    end
    cnt = 0;
    repeat (64) begin
      @(negedge clk);
      if (frame_tick === 1'b1) cnt++;
    end
    total++;
    if (cnt != 2) begin
      bad++;
      $display("FAIL tick_64 got %0d want 2", cnt);
    end
    cnt = 0;
    repeat (32) begin
      @(negedge clk);
      if (frame_tick === 1'b1) cnt++;
    end
    total++;
    if (cnt != 1) begin
      bad++;
      $display("FAIL tick_32 got %0d want 1", cnt);
    end
  endtask

  task automatic test_lz();
    logic [6:0] want1 [4];
    logic [6:0] want2 [4];
    logic [3:0] dpw2;
    bit ok;
    want1 = '{7'h6D, 7'h00, 7'h00, 7'h00};
    want2 = '{7'h6D, 7'h3F, 7'h3F, 7'h00};
    dpw2  = 4'b0100;
    lz = 1'b1;
    wr4(2'd3, 4'h0, 1'b0);
    wr4(2'd2, 4'h0, 1'b0);
    wr4(2'd1, 4'h0, 1'b0);
    wr4(2'd0, 4'h5, 1'b0);
    wait_ft(ok);
    for (int k = 0; k < N; k++) begin
      wait_sel(~(4'b0001 << k), ok);
      total++;
      if (!ok || seg_out !== want1[k] || dp_out !== 1'b0) begin
        bad++;
        $display("FAIL lz_seg idx=%0d ok=%0b got %h/%b want %h/0",
                 k, ok, seg_out, dp_out, want1[k]);
      end
    end
    wr4(2'd2, 4'h0, 1'b1);
    wait_ft(ok);
    for (int k = 0; k < N; k++) begin
      wait_sel(~(4'b0001 << k), ok);
      total++;
      if (!ok || seg_out !== want2[k] || dp_out !== dpw2[k]) begin
        bad++;
        $display("FAIL lz_dp idx=%0d ok=%0b got %h/%b want %h/%b",
                 k, ok, seg_out, dp_out, want2[k], dpw2[k]);
      end
    end
  endtask

  task automatic test_ignored_write();
    logic [2:0] addrs [4];
    logic [3:0] datas [4];
    logic [6:0] want;
    bit ok;
    int idx;
    int seen;
    addrs = '{3'd5, 3'd7, 3'd4, 3'd6};
    datas = '{4'h8, 4'h8, 4'h3, 4'h8};
    for (int k = 0; k < 4; k++) begin
      wr_en5 = 1'b1;
      wr_addr5 = addrs[k];
      wr_data5 = datas[k];
      @(negedge clk);
    end
    wr_en5 = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = (ft5 === 1'b1);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ign_tick got none want pulse");
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dig5 !== 5'b11111) begin
        idx = -1;
        for (int k = 0; k < 5; k++) if (dig5[k] === 1'b0) idx = k;
        want = (idx == 4) ? 7'h4F : 7'h3F;
        seen++;
        total++;
        if (seg5 !== want) begin
          bad++;
          $display("FAIL ign_seg sel=%b got %h want %h", dig5, seg5, want);
        end
      end
    end
    total++;
    if (seen != 30) begin
      bad++;
      $display("FAIL ign_active got %0d want 30", seen);
    end
  endtask

  task automatic test_midslot_write();
    bit ok;
    wait_ft(ok);
    wait_sel(4'b1101, ok);
    wr_en = 1'b1;
    wr_addr = 2'd1;
    wr_data = 4'h7;
    wr_dp = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    total++;
    if (!ok || seg_out !== 7'h3F) begin
      bad++;
      $display("FAIL mid_old ok=%0b got %h want 3f", ok, seg_out);
    end
    @(negedge clk);
    total++;
    if (seg_out !== 7'h07 || dig_sel !== 4'b1101) begin
      bad++;
      $display("FAIL mid_new got %h/%b want 07/1101", seg_out, dig_sel);
    end
  endtask

  task automatic test_ena();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = (m_slot == 4 && m_idx == 2);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ena_find got none want slot4/idx2");
    end
    ena = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({seg_out, dp_out, dig_sel, frame_tick} !== {7'h00, 1'b0, 4'hF, 1'b0}) begin
        bad++;
        $display("FAIL ena_off c=%0d got %h/%b/%b/%b want 00/0/1111/0",
                 c, seg_out, dp_out, dig_sel, frame_tick);
      end
    end
    ena = 1'b1;
    @(negedge clk);
    total++;
    if (dig_sel !== 4'b1011 || seg_out !== 7'h3F || dp_out !== 1'b1) begin
      bad++;
      $display("FAIL ena_resume got %b/%h/%b want 1011/3f/1",
               dig_sel, seg_out, dp_out);
    end
    repeat (3) @(negedge clk);
    total++;
    if (dig_sel !== 4'b1011) begin
      bad++;
      $display("FAIL ena_slot7 got %b want 1011", dig_sel);
    end
    @(negedge clk);
    total++;
    if (dig_sel !== 4'b1111 || seg_out !== 7'h00) begin
      bad++;
      $display("FAIL ena_next got %b/%h want 1111/00", dig_sel, seg_out);
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({seg_out, dp_out, dig_sel, frame_tick} !== {7'h00, 1'b0, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_off got %h/%b/%b/%b want 00/0/1111/0",
               seg_out, dp_out, dig_sel, frame_tick);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (dig_sel !== 4'b1111 || seg_out !== 7'h3F) begin
      bad++;
      $display("FAIL rstmid_c1 got %b/%h want 1111/3f", dig_sel, seg_out);
    end
    repeat (2) @(negedge clk);
    total++;
    if (dig_sel !== 4'b1110 || seg_out !== 7'h3F || dp_out !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_c3 got %b/%h/%b want 1110/3f/0",
               dig_sel, seg_out, dp_out);
    end
  endtask

  initial begin
    test_reset();
    test_writes();
    test_lz();
    test_ignored_write();
    test_midslot_write();
    test_ena();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
